// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the multicycle ARM-subset core (ADD/SUB/AND/ORR, LDR/STR
// with immediate offset, B). It contains the main FSM, the ALU decoder, the
// NZCV flags register and the conditional-execution gating. Each output
// connects to the datapath control input of the same name.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high
//   Instr       in  32   instruction register contents
//   ALUFlags    in   4   {N,Z,C,V} from the ALU, current cycle
//   PCWrite     out  1   PC register enable
//   MemWrite    out  1   memory write enable
//   RegWrite    out  1   register file write enable
//   IRWrite     out  1   instruction register enable
//   AdrSrc      out  1   0=PC, 1=ALUOut as memory address
//   RegSrc      out  2   [0]=Rn forced to R15 (B), [1]=Rm<-Rd (STR)
//   ALUSrcA     out  2   00=RD1, 01=PC, 10=ALUOut
//   ALUSrcB     out  2   00=RD2, 01=ExtImm, 10=constant 4
//   ResultSrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
//   ImmSrc      out  2   extend mode (= Instr[27:26])
//   ALUControl  out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
//   halted      out  1   only with CTRL_ILLEGAL_HALT_EN: core stopped on an
//                        undefined instruction
//
// Build option
//   CTRL_ILLEGAL_HALT_EN  when defined, an undefined instruction (Op=11)
//                         parks the FSM in HALT until reset instead of
//                         skipping the instruction.
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
`ifdef CTRL_ILLEGAL_HALT_EN
    ,
    output logic        halted
`endif
);

    // -------------------------------------------------------------------------
    // State encoding. S_HALT is only ever entered when the halt option is
    // built in; otherwise it is an unreachable code that recovers to FETCH.
    // -------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    // -------------------------------------------------------------------------
    // Instruction fields
    // -------------------------------------------------------------------------
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_unused;

    assign w_cond  = Instr[31:28];
    assign w_op    = Instr[27:26];
    assign w_funct = Instr[25:20];
    assign w_rd    = Instr[15:12];

    // Rn, Rm and the immediate/offset bits belong to the datapath only.
    assign w_unused = ^{Instr[19:16], Instr[11:0]};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t     r_state;
    state_t     w_next_state;
    state_t     w_state_eff;
    logic [3:0] r_flags;     // {N,Z,C,V}
    logic       r_cond_ok;   // condition result for the instruction in flight

    // Raw Moore controls before conditional gating
    logic       w_next_pc;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_branch;
    logic       w_alu_op;
    logic       w_ir_write;
    logic       w_adr_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    logic       w_pcs;
    logic       w_flags_upd;

    // -------------------------------------------------------------------------
    // Condition check against the architectural flags.
    // -------------------------------------------------------------------------
    function automatic logic cond_ex(input logic [3:0] cond,
                                     input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic ok;
        {n, z, c, v} = flags;
        case (cond)
            4'h0:    ok = z;                     // EQ
            4'h1:    ok = ~z;                    // NE
            4'h2:    ok = c;                     // CS
            4'h3:    ok = ~c;                    // CC
            4'h4:    ok = n;                     // MI
            4'h5:    ok = ~n;                    // PL
            4'h6:    ok = v;                     // VS
            4'h7:    ok = ~v;                    // VC
            4'h8:    ok = c & ~z;                // HI
            4'h9:    ok = ~c | z;                // LS
            4'hA:    ok = (n == v);              // GE
            4'hB:    ok = (n != v);              // LT
            4'hC:    ok = ~z & (n == v);         // GT
            4'hD:    ok = z | (n != v);          // LE
            4'hE:    ok = 1'b1;                  // AL
            default: ok = 1'b0;                  // 1111: never executes
        endcase
        return ok;
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the case statements can leave it unassigned (no latch).
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    2'b00:   w_next_state = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next_state = S_MEMADR;
                    2'b10:   w_next_state = S_BRANCH;
                    default: w_next_state = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   w_next_state = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
`ifdef CTRL_ILLEGAL_HALT_EN
            S_UNKNOWN:  w_next_state = S_HALT;
            S_HALT:     w_next_state = S_HALT;   // only reset leaves HALT
`else
            S_UNKNOWN:  w_next_state = S_FETCH;  // instruction skipped
            S_HALT:     w_next_state = S_FETCH;
`endif
            default:    w_next_state = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore output decode. While reset is high the selects already show their
    // FETCH values, so the datapath sees a clean FETCH the moment reset drops.
    // -------------------------------------------------------------------------
    assign w_state_eff = reset ? S_FETCH : r_state;

    always_comb begin
        w_next_pc    = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = 1'b0;
        w_ir_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        case (w_state_eff)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_next_pc    = 1'b1;
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
            end
            S_DECODE: begin
                // PC+8 is formed here for instructions that read R15
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
            end
            S_MEMADR: begin
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b01;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                w_mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b01;
                w_alu_op     = 1'b1;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_w      = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_result_src = 2'b10;
                w_branch     = 1'b1;
            end
            default: begin
                // S_UNKNOWN and S_HALT: every enable and select stays at 0
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // ALU decoder: only DP execute states use the Funct command field.
    // -------------------------------------------------------------------------
    always_comb begin
        ALUControl = 2'b00;
        if (w_alu_op) begin
            case (w_funct[4:1])
                4'b0100: ALUControl = 2'b00;   // ADD
                4'b0010: ALUControl = 2'b01;   // SUB
                4'b0000: ALUControl = 2'b10;   // AND
                4'b1100: ALUControl = 2'b11;   // ORR
                default: ALUControl = 2'b00;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Condition latch and flags register
    // -------------------------------------------------------------------------
    // cond_ok is evaluated once in DECODE against the flags as they stand
    // before this instruction, and held for the rest of the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cond_ok <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_cond_ok <= cond_ex(w_cond, r_flags);
        end
    end

    // S bit set and condition passed, in an execute state. Logical ops
    // (AND/ORR, ALUControl[1]=1) leave C and V untouched.
    assign w_flags_upd = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI))
                         && w_funct[0] && r_cond_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_flags_upd) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (!ALUControl[1]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Gated enables. A failed condition suppresses register, memory and
    // PC-redirect writes but never the PC+4 update in FETCH.
    // -------------------------------------------------------------------------
    assign w_pcs = ((w_rd == 4'd15) & w_reg_w) | w_branch;

    assign PCWrite  = ~reset & (w_next_pc | (w_pcs & r_cond_ok));
    assign RegWrite = ~reset & w_reg_w & r_cond_ok;
    assign MemWrite = ~reset & w_mem_w & r_cond_ok;
    assign IRWrite  = ~reset & w_ir_write;

    assign AdrSrc    = w_adr_src;
    assign ALUSrcA   = w_alu_src_a;
    assign ALUSrcB   = w_alu_src_b;
    assign ResultSrc = w_result_src;

    // Instruction-only decodes, independent of state
    assign ImmSrc    = w_op;
    assign RegSrc[0] = (w_op == 2'b10);
    assign RegSrc[1] = (w_op == 2'b01);

`ifdef CTRL_ILLEGAL_HALT_EN
    assign halted = (w_state_eff == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed, table-driven bench for multicycle_controller. Each table record is
// one clock cycle: inputs to drive and the hand-computed output word expected
// in that cycle. Reset-in-flight and undefined-instruction behaviour are run
// as hand-written sequences after the table. Build with CTRL_ILLEGAL_HALT_EN
// defined to exercise the HALT option.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
`ifdef CTRL_ILLEGAL_HALT_EN
    logic        halted;
`endif

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
`ifdef CTRL_ILLEGAL_HALT_EN
        ,
        .halted     (halted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word, MSB first: PCWrite MemWrite RegWrite IRWrite AdrSrc
    // RegSrc ALUSrcA ALUSrcB ResultSrc ImmSrc ALUControl
    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] regsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] aluc;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic [3:0]  flags;
        out_t        exp;
    } vec_t;

    vec_t  vecs[$];
    string names[$];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD    = 32'hE0821003;  // ADD   R1,R2,R3
    localparam logic [31:0] I_LDR    = 32'hE5901004;  // LDR   R1,[R0,#4]
    localparam logic [31:0] I_STR    = 32'hE5801004;  // STR   R1,[R0,#4]
    localparam logic [31:0] I_SUBS   = 32'hE2500001;  // SUBS  R0,R0,#1
    localparam logic [31:0] I_BEQ    = 32'h0A000002;
    localparam logic [31:0] I_BNE    = 32'h1A000002;
    localparam logic [31:0] I_BCS    = 32'h2A000002;
    localparam logic [31:0] I_BLT    = 32'hBA000002;
    localparam logic [31:0] I_ADDNE  = 32'h10821003;
    localparam logic [31:0] I_ADDSNE = 32'h10921003;
    localparam logic [31:0] I_ADDPC  = 32'hE082F003;  // ADD   PC,R2,R3
    localparam logic [31:0] I_ORRS   = 32'hE1921003;
    localparam logic [31:0] I_AND    = 32'hE0021003;
    localparam logic [31:0] I_EOR    = 32'hE0221003;  // unsupported cmd -> ADD
    localparam logic [31:0] I_ADDNV  = 32'hF0821003;  // cond 1111
    localparam logic [31:0] I_UND    = 32'hEC000000;  // Op=11

    function automatic out_t mk(input logic pcw, input logic memw,
                                input logic regw, input logic irw,
                                input logic adr, input logic [1:0] rs,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] res, input logic [1:0] imm,
                                input logic [1:0] alu);
        return {pcw, memw, regw, irw, adr, rs, sa, sb, res, imm, alu};
    endfunction

    // Constant output words that recur for every instruction
    function automatic out_t w_fetch(input logic [1:0] imm, input logic [1:0] rs);
        return mk(1, 0, 0, 1, 0, rs, 2'b01, 2'b10, 2'b10, imm, 2'b00);
    endfunction

    function automatic out_t w_decode(input logic [1:0] imm, input logic [1:0] rs);
        return mk(0, 0, 0, 0, 0, rs, 2'b01, 2'b10, 2'b10, imm, 2'b00);
    endfunction

    // Reset shows FETCH selects with every enable off (same word as DECODE)
    function automatic out_t w_reset(input logic [1:0] imm, input logic [1:0] rs);
        return mk(0, 0, 0, 0, 0, rs, 2'b01, 2'b10, 2'b10, imm, 2'b00);
    endfunction

    task automatic add(input logic rst, input logic [31:0] ins,
                       input logic [3:0] fl, input out_t e, input string nm);
        vecs.push_back({rst, ins, fl, e});
        names.push_back(nm);
    endtask

    // DP instruction: FETCH, DECODE, EXECUTE(R/I), ALUWB. ImmSrc=00, RegSrc=00.
    task automatic add_dp(input logic [31:0] ins, input logic [3:0] ex_flags,
                          input logic is_imm, input logic [1:0] aluc,
                          input logic wb_pcw, input logic wb_regw,
                          input string nm);
        add(0, ins, 4'h0, w_fetch(2'b00, 2'b00), {nm, ".fetch"});
        add(0, ins, 4'h0, w_decode(2'b00, 2'b00), {nm, ".decode"});
        add(0, ins, ex_flags,
            mk(0, 0, 0, 0, 0, 2'b00, 2'b00, is_imm ? 2'b01 : 2'b00, 2'b00, 2'b00, aluc),
            {nm, ".exec"});
        add(0, ins, 4'h0,
            mk(wb_pcw, 0, wb_regw, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00),
            {nm, ".aluwb"});
    endtask

    // Branch: FETCH, DECODE, BRANCH. ImmSrc=10, RegSrc=01.
    task automatic add_br(input logic [31:0] ins, input logic taken, input string nm);
        add(0, ins, 4'h0, w_fetch(2'b10, 2'b01), {nm, ".fetch"});
        add(0, ins, 4'h0, w_decode(2'b10, 2'b01), {nm, ".decode"});
        add(0, ins, 4'h0,
            mk(taken, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00),
            {nm, ".branch"});
    endtask

    task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h (pcw%b memw%b regw%b irw%b adr%b rs%b sa%b sb%b res%b imm%b alu%b) want %05h",
                     nm, act, act[16], act[15], act[14], act[13], act[12],
                     act[11:10], act[9:8], act[7:6], act[5:4], act[3:2], act[1:0], exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, sample 1 ns later,
    // well clear of the next rising edge.
    task automatic cyc(input logic rst, input logic [31:0] ins, input logic [3:0] fl,
                       input out_t e, input logic exp_halt, input string nm);
        out_t act;
        @(negedge clk);
        reset    = rst;
        Instr    = ins;
        ALUFlags = fl;
        #1;
        act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
        check(nm, act, e);
`ifdef CTRL_ILLEGAL_HALT_EN
        checks++;
        if (halted !== exp_halt) begin
            errors++;
            $display("FAIL %s.halted: got %b want %b", nm, halted, exp_halt);
        end
`else
        if (exp_halt) begin
            // no halted port in this build; nothing to compare
        end
`endif
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 32'h0;
        ALUFlags = 4'h0;

        // ---------------- table ----------------
        add(1, I_ADD, 4'h0, w_reset(2'b00, 2'b00), "reset");
        add_dp(I_ADD, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1, "add");

        // LDR: ImmSrc=01, RegSrc=10, five cycles
        add(0, I_LDR, 4'h0, w_fetch(2'b01, 2'b10), "ldr.fetch");
        add(0, I_LDR, 4'h0, w_decode(2'b01, 2'b10), "ldr.decode");
        add(0, I_LDR, 4'h0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00), "ldr.memadr");
        add(0, I_LDR, 4'h0, mk(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00), "ldr.memread");
        add(0, I_LDR, 4'h0, mk(0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00), "ldr.memwb");

        // STR: single MemWrite cycle, no RegWrite, four cycles
        add(0, I_STR, 4'h0, w_fetch(2'b01, 2'b10), "str.fetch");
        add(0, I_STR, 4'h0, w_decode(2'b01, 2'b10), "str.decode");
        add(0, I_STR, 4'h0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00), "str.memadr");
        add(0, I_STR, 4'h0, mk(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00), "str.memwrite");

        // SUBS sets flags to 0110 (Z=1, C=1)
        add_dp(I_SUBS, 4'b0110, 1'b1, 2'b01, 1'b0, 1'b1, "subs");
        add_br(I_BEQ, 1'b1, "beq_z1");
        add_br(I_BNE, 1'b0, "bne_z1");
        // Failed condition: full walk, no writes, flags left alone even with S
        add_dp(I_ADDNE, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, "addne");
        add_dp(I_ADDSNE, 4'b1000, 1'b0, 2'b00, 1'b0, 1'b0, "addsne");
        add_br(I_BEQ, 1'b1, "beq_kept");
        // Write to R15 redirects the PC in ALUWB
        add_dp(I_ADDPC, 4'h0, 1'b0, 2'b00, 1'b1, 1'b1, "add_pc");
        // ORRS with ALUFlags=1000: N,Z <- 1,0; C,V keep 1,0 -> flags 1010
        add_dp(I_ORRS, 4'b1000, 1'b0, 2'b11, 1'b0, 1'b1, "orrs");
        add_br(I_BCS, 1'b1, "bcs_c_kept");
        add_br(I_BLT, 1'b1, "blt");
        add_br(I_BEQ, 1'b0, "beq_z0");
        add_dp(I_AND, 4'h0, 1'b0, 2'b10, 1'b0, 1'b1, "and");
        add_dp(I_EOR, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1, "eor");
        add_dp(I_ADDNV, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, "add_nv");

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].instr, vecs[i].flags, vecs[i].exp, 1'b0, names[i]);
        end

        // ---------------- reset while in MEMREAD ----------------
        cyc(0, I_LDR, 4'h0, w_fetch(2'b01, 2'b10), 1'b0, "rst_mid.fetch");
        cyc(0, I_LDR, 4'h0, w_decode(2'b01, 2'b10), 1'b0, "rst_mid.decode");
        cyc(0, I_LDR, 4'h0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00), 1'b0, "rst_mid.memadr");
        cyc(1, I_LDR, 4'h0, w_reset(2'b01, 2'b10), 1'b0, "rst_mid.in_reset");
        // Flags were 1010 (C=1); after reset C=0 so BCS is not taken
        cyc(0, I_BCS, 4'h0, w_fetch(2'b10, 2'b01), 1'b0, "rst_mid.next_fetch");
        cyc(0, I_BCS, 4'h0, w_decode(2'b10, 2'b01), 1'b0, "rst_mid.bcs.decode");
        cyc(0, I_BCS, 4'h0, mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00), 1'b0, "rst_mid.bcs_flags_clear");

        // ---------------- undefined instruction ----------------
        cyc(0, I_UND, 4'h0, w_fetch(2'b11, 2'b00), 1'b0, "und.fetch");
        cyc(0, I_UND, 4'h0, w_decode(2'b11, 2'b00), 1'b0, "und.decode");
        cyc(0, I_UND, 4'h0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00), 1'b0, "und.unknown");
`ifdef CTRL_ILLEGAL_HALT_EN
        for (int k = 0; k < 3; k++) begin
            cyc(0, I_ADD, 4'h0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1, "und.halt");
        end
        cyc(1, I_ADD, 4'h0, w_reset(2'b00, 2'b00), 1'b0, "und.halt_reset");
        cyc(0, I_ADD, 4'h0, w_fetch(2'b00, 2'b00), 1'b0, "und.after_reset_fetch");
`else
        cyc(0, I_ADD, 4'h0, w_fetch(2'b00, 2'b00), 1'b0, "und.next_fetch");
        cyc(0, I_ADD, 4'h0, w_decode(2'b00, 2'b00), 1'b0, "und.next_decode");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
